effect_ctrl: RTL and testbench

EFFECT_CTRL -- requirements
Module: effect_ctrl

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/key_cond.sv | 94 +++++++++
 rtl/effect_ctrl.sv | 139 +++++++++++++
 tb/tb_effect_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
//==============================================================================
// Module : ctrl_pkg
// Brief  : Default parameter constants and page encodings for effect_ctrl.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int c_n_en_def       = 4;
    localparam int c_n_btn_def      = 4;
    localparam int c_n_page_def     = 8;
    localparam int c_deb_cyc_def    = 500000;
    localparam int c_repeat_dly_def = 25000000;
    localparam int c_repeat_per_def = 5000000;

    typedef enum logic [2:0] {
        BRIGHT_CONTRAST = 3'd0,
        COLOR_TEMP      = 3'd1,
        SATURATION      = 3'd2,
        SHARPNESS       = 3'd3,
        GAMMA           = 3'd4,
        NOISE_REDUCE    = 3'd5,
        ZOOM            = 3'd6,
        CURSOR_SIZE     = 3'd7
    } page_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_cond.sv
//==============================================================================
// Module : key_cond
// Brief  : One button: 2-flop sync, debounce and auto-repeat timing.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_cond
    import ctrl_pkg::*;
#(
    parameter int DEB_CYC    = c_deb_cyc_def,
    parameter int REPEAT_DLY = c_repeat_dly_def,
    parameter int REPEAT_PER = c_repeat_per_def
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic state,
    output logic press,
    output logic rep
);

    localparam int c_rep_max = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int c_deb_w   = cnt_width(DEB_CYC);
    localparam int c_rep_w   = cnt_width(c_rep_max);

    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYC - 1);
    localparam logic [c_rep_w-1:0] c_dly_last = c_rep_w'(REPEAT_DLY - 1);
    localparam logic [c_rep_w-1:0] c_per_last = c_rep_w'(REPEAT_PER - 1);

    logic [1:0]         r_sync;
    logic               r_state;
    logic               r_press;
    logic               r_rep;
    logic               r_first;
    logic [c_deb_w-1:0] r_deb_cnt;
    logic [c_rep_w-1:0] r_rep_cnt;

    logic               w_sample;
    logic               w_differs;
    logic               w_accept;
    logic [c_rep_w-1:0] w_rep_last;

    assign w_sample   = ~r_sync[1];
    assign w_differs  = (w_sample != r_state);
    assign w_accept   = w_differs && (r_deb_cnt == c_deb_last);
    assign w_rep_last = r_first ? c_dly_last : c_per_last;

    // Both counters reset on reaching their terminal value, so they never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_rep     <= 1'b0;
            r_first   <= 1'b1;
            r_deb_cnt <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_press <= 1'b0;
            r_rep   <= 1'b0;

            if (!w_differs) begin
                r_deb_cnt <= '0;
            end else if (w_accept) begin
                r_deb_cnt <= '0;
                r_state   <= w_sample;
                r_press   <= w_sample;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end

            // The press pulse itself restarts the repeat timer.
            if (w_accept || !r_state) begin
                r_rep_cnt <= '0;
                r_first   <= 1'b1;
            end else if (r_rep_cnt == w_rep_last) begin
                r_rep_cnt <= '0;
                r_first   <= 1'b0;
                r_rep     <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    assign state = r_state;
    assign press = r_press;
    assign rep   = r_rep;

endmodule

`default_nettype wire

// File: rtl/effect_ctrl.sv
//==============================================================================
// Module : effect_ctrl
// Brief  : Effect enables, page select with key lockout, per-page key pulses.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module effect_ctrl
    import ctrl_pkg::*;
#(
    parameter int                   N_EN        = c_n_en_def,
    parameter int                   N_BTN       = c_n_btn_def,
    parameter int                   N_PAGE      = c_n_page_def,
    parameter int                   DEB_CYC     = c_deb_cyc_def,
    parameter int                   REPEAT_DLY  = c_repeat_dly_def,
    parameter int                   REPEAT_PER  = c_repeat_per_def,
    parameter logic [N_PAGE-1:0]    REPEAT_MASK = '0,
    parameter logic [N_EN*N_EN-1:0] IMPLY       = '0,
    localparam int                  PAGE_W      = (N_PAGE > 1) ? $clog2(N_PAGE) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_EN-1:0]         sw_en,
    input  logic [PAGE_W-1:0]       sw_page,
    input  logic [N_BTN-1:0]        key_n,
    output logic [N_EN-1:0]         en,
    output logic [PAGE_W-1:0]       page,
    output logic                    page_chg,
    output logic [N_PAGE*N_BTN-1:0] pulse,
    output logic [N_BTN-1:0]        hold
);

    logic [N_EN-1:0]         r_en_s1;
    logic [N_EN-1:0]         r_en_s2;
    logic [PAGE_W-1:0]       r_pg_s1;
    logic [PAGE_W-1:0]       r_pg_s2;
    logic [N_EN-1:0]         r_en;
    logic [PAGE_W-1:0]       r_page;
    logic                    r_page_chg;
    logic                    r_lockout;
    logic [N_PAGE*N_BTN-1:0] r_pulse;
    logic [N_BTN-1:0]        r_hold;

    logic [N_BTN-1:0]        w_state;
    logic [N_BTN-1:0]        w_press;
    logic [N_BTN-1:0]        w_rep;
    logic [N_BTN-1:0]        w_ev;
    logic [N_EN-1:0]         w_en_nxt;
    logic [N_PAGE*N_BTN-1:0] w_pulse_nxt;
    logic                    w_rep_en;
    logic                    w_page_upd;
    logic                    w_lock_now;

    for (genvar b = 0; b < N_BTN; b++) begin : g_key
        key_cond #(
            .DEB_CYC    (DEB_CYC),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_key_cond (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[b]),
            .state (w_state[b]),
            .press (w_press[b]),
            .rep   (w_rep[b])
        );
    end

    assign w_page_upd = (r_pg_s2 != r_page);
    // A page change suppresses events in the same cycle it happens.
    assign w_lock_now = r_lockout | w_page_upd;

    // Single level of implication only; implied bits do not imply further.
    always_comb begin
        w_en_nxt = r_en_s2;
        for (int i = 0; i < N_EN; i++) begin
            if (r_en_s2[i]) begin
                w_en_nxt = w_en_nxt | IMPLY[i*N_EN +: N_EN];
            end
        end
    end

    always_comb begin
        w_rep_en = 1'b0;
        for (int p = 0; p < N_PAGE; p++) begin
            if (r_page == PAGE_W'(p)) begin
                w_rep_en = REPEAT_MASK[p];
            end
        end
        w_ev        = w_press | (w_rep & {N_BTN{w_rep_en}});
        w_pulse_nxt = '0;
        if (!w_lock_now) begin
            for (int p = 0; p < N_PAGE; p++) begin
                for (int b = 0; b < N_BTN; b++) begin
                    w_pulse_nxt[p*N_BTN + b] = (r_page == PAGE_W'(p)) && w_ev[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_s1    <= '0;
            r_en_s2    <= '0;
            r_pg_s1    <= '0;
            r_pg_s2    <= '0;
            r_en       <= '0;
            r_page     <= '0;
            r_page_chg <= 1'b0;
            r_lockout  <= 1'b0;
            r_pulse    <= '0;
            r_hold     <= '0;
        end else begin
            r_en_s1    <= sw_en;
            r_en_s2    <= r_en_s1;
            r_pg_s1    <= sw_page;
            r_pg_s2    <= r_pg_s1;
            r_en       <= w_en_nxt;
            r_page_chg <= w_page_upd;
            if (w_page_upd) begin
                r_page    <= r_pg_s2;
                r_lockout <= 1'b1;
            end else if (r_lockout && !(|w_state)) begin
                r_lockout <= 1'b0;
            end
            r_pulse <= w_pulse_nxt;
            r_hold  <= w_lock_now ? '0 : w_state;
        end
    end

    assign en       = r_en;
    assign page     = r_page;
    assign page_chg = r_page_chg;
    assign pulse    = r_pulse;
    assign hold     = r_hold;

endmodule

`default_nettype wire

// File: tb/tb_effect_ctrl.sv
//==============================================================================
// Module : tb_effect_ctrl
// Brief  : Directed, table-driven bench for effect_ctrl.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_effect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_en;
    logic [2:0]  sw_page;
    logic [3:0]  key_n;
    logic [3:0]  en;
    logic [2:0]  page;
    logic        page_chg;
    logic [31:0] pulse;
    logic [3:0]  hold;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] sw_en;
        logic [3:0] exp_en;
    } en_vec_t;

    en_vec_t vecs [7];

    effect_ctrl #(
        .N_EN        (4),
        .N_BTN       (4),
        .N_PAGE      (8),
        .DEB_CYC     (4),
        .REPEAT_DLY  (20),
        .REPEAT_PER  (8),
        .REPEAT_MASK (8'h01),
        .IMPLY       (16'h0840)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_en    (sw_en),
        .sw_page  (sw_page),
        .key_n    (key_n),
        .en       (en),
        .page     (page),
        .page_chg (page_chg),
        .pulse    (pulse),
        .hold     (hold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int chg_cnt;

        // IMPLY slice1 = 0100, slice2 = 1000; others empty.
        vecs[0] = '{sw_en: 4'b0000, exp_en: 4'b0000};
        vecs[1] = '{sw_en: 4'b0010, exp_en: 4'b0110};
        vecs[2] = '{sw_en: 4'b0100, exp_en: 4'b1100};
        vecs[3] = '{sw_en: 4'b0110, exp_en: 4'b1110};
        vecs[4] = '{sw_en: 4'b0001, exp_en: 4'b0001};
        vecs[5] = '{sw_en: 4'b1000, exp_en: 4'b1000};
        vecs[6] = '{sw_en: 4'b1111, exp_en: 4'b1111};

        // Reset with busy inputs: outputs must stay 0.
        rst = 1'b1; sw_en = 4'hF; sw_page = 3'd3; key_n = 4'hF;
        ticks(3);
        chk("rst_en", en, 0);
        chk("rst_page", page, 0);
        chk("rst_page_chg", page_chg, 0);
        chk("rst_pulse", pulse, 0);
        chk("rst_hold", hold, 0);

        // Nonzero sw_page after reset: page update on 3rd edge.
        rst = 1'b0;
        ticks(2);
        chk("post_rst_page_e2", page, 0);
        tick();
        chk("post_rst_page_e3", page, 3);
        chk("post_rst_chg_e3", page_chg, 1);
        tick();
        chk("post_rst_chg_e4", page_chg, 0);

        // Page 3: all keys pressed together pulse in one cycle.
        key_n = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("all_keys_k%0d", k), pulse, (k == 7) ? 32'h0000_F000 : 32'h0);
        end
        key_n = 4'hF;
        ticks(10);

        // Enable implication table, 3-edge latency.
        sw_en = 4'b0000;
        ticks(4);
        sw_en = 4'b0010;
        ticks(2);
        chk("en_lat_e2", en, 4'b0000);
        tick();
        chk("en_lat_e3", en, 4'b0110);
        foreach (vecs[i]) begin
            sw_en = vecs[i].sw_en;
            ticks(3);
            chk($sformatf("en_vec%0d", i), en, vecs[i].exp_en);
        end
        sw_en = 4'b0000;

        // Back to page 0 (repeat enabled).
        sw_page = 3'd0;
        ticks(6);
        chk("page0", page, 0);

        // Long press on key 3 with auto-repeat, released after 50 cycles.
        key_n = 4'b0111;
        for (int k = 1; k <= 70; k++) begin
            tick();
            chk($sformatf("rep_pulse_k%0d", k), pulse,
                (k == 7 || k == 27 || k == 35 || k == 43 || k == 51) ? 32'h8 : 32'h0);
            chk($sformatf("rep_hold_k%0d", k), hold,
                (k >= 7 && k <= 56) ? 4'h8 : 4'h0);
            if (k == 50) key_n = 4'hF;
        end

        // Short glitch on key 0 is rejected.
        key_n = 4'b1110;
        ticks(3);
        key_n = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("glitch_pulse_k%0d", k), pulse, 0);
            chk($sformatf("glitch_hold_k%0d", k), hold, 0);
        end

        // Page 2, hold key 1 across a change to page 5.
        sw_page = 3'd2;
        ticks(6);
        chk("page2", page, 2);
        key_n = 4'b1101;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("p2_pulse_k%0d", k), pulse, (k == 7) ? 32'h0000_0200 : 32'h0);
        end
        sw_page = 3'd5;
        chg_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (page_chg) chg_cnt++;
            if (k == 3) chk("p5_page", page, 5);
            chk($sformatf("p5_lock_pulse_k%0d", k), pulse, 0);
            if (k >= 3) chk($sformatf("p5_lock_hold_k%0d", k), hold, 0);
        end
        chk("p5_chg_count", chg_cnt, 1);
        key_n = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("p5_rel_pulse_k%0d", k), pulse, 0);
        end
        key_n = 4'b1101;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("p5_new_pulse_k%0d", k), pulse, (k == 7) ? 32'h0020_0000 : 32'h0);
        end
        key_n = 4'hF;
        ticks(10);

        // Reset in the middle of a page-0 repeat.
        sw_page = 3'd0;
        ticks(6);
        key_n = 4'b0111;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk($sformatf("mid_pulse_k%0d", k), pulse, (k == 7 || k == 27) ? 32'h8 : 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_pulse", pulse, 0);
        chk("mid_rst_hold", hold, 0);
        chk("mid_rst_page", page, 0);
        chk("mid_rst_chg", page_chg, 0);
        chk("mid_rst_en", en, 0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("after_rst_pulse_k%0d", k), pulse, (k == 7) ? 32'h8 : 32'h0);
        end
        key_n = 4'hF;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
